bit_serializer: RTL



---
 rtl/ser_pkg.sv | 31 +++
 rtl/ser_hold_buf.sv | 49 ++++
 rtl/bit_serializer.sv | 151 +++++++++++++++
 3 files changed

// File: rtl/ser_pkg.sv
// ============================================================================
// Module      : ser_pkg
// Description : Shared types, constants and helpers for the bit serializer.
//               State enum, default word width, counter width function and
//               the even-parity helper used when SER_PARITY_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package ser_pkg;

    localparam int DEF_DATA_W = 8;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } ser_state_t;

    // Counter must be able to hold DATA_W itself (parity frames reload to DATA_W).
    function automatic int cnt_w(input int w);
        return $clog2(w + 1);
    endfunction

    // Even parity over a zero-extended word; zero padding does not alter the XOR.
    function automatic logic even_parity(input logic [31:0] d);
        return ^d;
    endfunction

endpackage

`default_nettype wire

// File: rtl/ser_hold_buf.sv
// ============================================================================
// Module      : ser_hold_buf
// Description : Single-entry holding register with a valid flag. Absorbs the
//               next word while the current word is shifting out.
// Ports       : clk, rst      - clock, synchronous active-high reset
//               i_wr/i_wr_data - store a word (sets valid)
//               i_rd          - consume the stored word (clears valid)
//               o_valid/o_data - occupancy flag and stored word
//               Write and read never coincide: the parent only writes when
//               the buffer is empty and only reads when it is full.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ser_hold_buf
    import ser_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_wr,
    input  logic [DATA_W-1:0] i_wr_data,
    input  logic              i_rd,
    output logic              o_valid,
    output logic [DATA_W-1:0] o_data
);

    logic              r_valid;
    logic [DATA_W-1:0] r_data;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid <= 1'b0;
            r_data  <= '0;
        end else if (i_wr) begin
            r_valid <= 1'b1;
            r_data  <= i_wr_data;
        end else if (i_rd) begin
            r_valid <= 1'b0;
        end
    end

    assign o_valid = r_valid;
    assign o_data  = r_data;

endmodule

`default_nettype wire

// File: rtl/bit_serializer.sv
// ============================================================================
// Module      : bit_serializer
// Description : Parallel-to-serial front end feeding a "1011" detector.
//               Accepts DATA_W-bit words on a valid/ready handshake and shifts
//               them out one bit per shift_en cycle with no gap between
//               back-to-back words. A one-entry buffer holds the next word.
// Ports       : clk, rst             - clock, synchronous active-high reset
//               din/din_valid/din_ready - parallel word handshake
//               shift_en             - advance the serial stream
//               ser_out/ser_valid    - serial bit and its qualifier
//               busy                 - shifting or holding a pending word
//               frame_done           - pulse on consumption of a frame's last bit
// Options     : SER_PARITY_EN - append an even-parity bit to every frame
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module bit_serializer
    import ser_pkg::*;
#(
    parameter int DATA_W    = DEF_DATA_W,
    parameter int MSB_FIRST = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] din,
    input  logic              din_valid,
    output logic              din_ready,
    input  logic              shift_en,
    output logic              ser_out,
    output logic              ser_valid,
    output logic              busy,
    output logic              frame_done
);

    localparam int CNT_W = cnt_w(DATA_W);
`ifdef SER_PARITY_EN
    localparam int SR_W = DATA_W + 1;
`else
    localparam int SR_W = DATA_W;
`endif
    localparam logic [CNT_W-1:0] CNT_RELOAD = CNT_W'(SR_W - 1);
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

    ser_state_t        r_state, w_state_nxt;
    logic [CNT_W-1:0]  r_cnt, w_cnt_nxt;
    logic [SR_W-1:0]   r_shreg, w_shreg_nxt;
    logic [SR_W-1:0]   w_shifted;
    logic              w_head;
    logic              w_pend_valid;
    logic [DATA_W-1:0] w_pend_data;
    logic              w_buf_wr, w_buf_rd;
    logic              w_xfer, w_last;

    // Frame image as loaded into the shift register. With parity, the parity
    // bit sits on the far side of the head so it leaves after the data bits.
    function automatic logic [SR_W-1:0] frame_of(input logic [DATA_W-1:0] d);
`ifdef SER_PARITY_EN
        logic p;
        p = even_parity(32'(d));
        if (MSB_FIRST != 0) return {d, p};
        else                return {p, d};
`else
        return d;
`endif
    endfunction

    generate
        if (MSB_FIRST != 0) begin : g_msb_first
            assign w_head    = r_shreg[SR_W-1];
            assign w_shifted = {r_shreg[SR_W-2:0], 1'b0};
        end else begin : g_lsb_first
            assign w_head    = r_shreg[0];
            assign w_shifted = {1'b0, r_shreg[SR_W-1:1]};
        end
    endgenerate

    ser_hold_buf #(.DATA_W(DATA_W)) u_hold_buf (
        .clk       (clk),
        .rst       (rst),
        .i_wr      (w_buf_wr),
        .i_wr_data (din),
        .i_rd      (w_buf_rd),
        .o_valid   (w_pend_valid),
        .o_data    (w_pend_data)
    );

    assign din_ready = !rst && !w_pend_valid;
    assign w_xfer    = din_valid && din_ready;
    assign w_last    = (r_state == SHIFT) && (r_cnt == '0) && shift_en;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_shreg <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_shreg <= w_shreg_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_shreg_nxt = r_shreg;
        w_buf_wr    = 1'b0;
        w_buf_rd    = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_xfer) begin
                    w_shreg_nxt = frame_of(din);
                    w_cnt_nxt   = CNT_RELOAD;
                    w_state_nxt = SHIFT;
                end
            end
            SHIFT: begin
                // On the last-bit edge an arriving word bypasses the buffer.
                if (w_xfer && !w_last) begin
                    w_buf_wr = 1'b1;
                end
                if (shift_en) begin
                    if (r_cnt != '0) begin
                        w_shreg_nxt = w_shifted;
                        w_cnt_nxt   = r_cnt - CNT_ONE;
                    end else if (w_pend_valid) begin
                        w_shreg_nxt = frame_of(w_pend_data);
                        w_cnt_nxt   = CNT_RELOAD;
                        w_buf_rd    = 1'b1;
                    end else if (w_xfer) begin
                        w_shreg_nxt = frame_of(din);
                        w_cnt_nxt   = CNT_RELOAD;
                    end else begin
                        w_state_nxt = IDLE;
                    end
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // Outputs are forced low while reset is asserted, before the clearing edge.
    assign ser_valid  = !rst && (r_state == SHIFT);
    assign ser_out    = ser_valid && w_head;
    assign busy       = !rst && ((r_state == SHIFT) || w_pend_valid);
    assign frame_done = !rst && w_last;

endmodule

`default_nettype wire
